alu16_unit: RTL and testbench

Two-pass 16-bit arithmetic unit for the CPU's 16-bit operations: ADD HL,rr, INC rr, DEC rr and ADD SP,e8 / LD HL,SP+e8. It sits directly upstream of the 8-bit ALU's flag path. It computes the low byte and then the high byte on consecutive cycles, matching the 8-bit datapath timing. It presents the 16-bit result to the register file and the new ZNHC flags to the ALU's `i_External_Flags` input for one cycle.

---
 rtl/alu16_unit_if.sv | 23 ++
 rtl/alu16_unit.sv | 120 ++++++++++++
 tb/tb_alu16_unit.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/alu16_unit_if.sv
// Request/response bundle for alu16_unit: start/operands in, status/result/flags out.
interface alu16_unit_if;
    logic        i_Enable;
    logic        i_Start;
    logic [1:0]  i_Op;
    logic [15:0] i_A;
    logic [15:0] i_B;
    logic [3:0]  i_F;
    logic        o_Busy;
    logic        o_Done;
    logic [15:0] o_Result;
    logic        o_Flags_Valid;
    logic [3:0]  o_External_Flags;

    modport master (
        output i_Enable, i_Start, i_Op, i_A, i_B, i_F,
        input  o_Busy, o_Done, o_Result, o_Flags_Valid, o_External_Flags
    );
    modport slave (
        input  i_Enable, i_Start, i_Op, i_A, i_B, i_F,
        output o_Busy, o_Done, o_Result, o_Flags_Valid, o_External_Flags
    );
endinterface

// File: rtl/alu16_unit.sv
// Two-pass 16-bit ALU (ADD16/INC16/DEC16/ADDSPE): low byte then high byte, flags in DONE.
// Define ALU16_SP_OFFSET_EN to enable ADDSPE (op 11); otherwise op 11 requests are ignored.
module alu16_unit (
    input  logic        i_Clk,
    input  logic        i_Rst,
    alu16_unit_if.slave bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOW  = 2'd1;
    localparam logic [1:0] S_HIGH = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [1:0] OP_ADD16  = 2'b00;
    localparam logic [1:0] OP_INC16  = 2'b01;
    localparam logic [1:0] OP_DEC16  = 2'b10;
    localparam logic [1:0] OP_ADDSPE = 2'b11;

    logic [1:0]  state_q, state_d;
    logic [1:0]  op_q;
    logic [15:0] a_q, b_q, result_q;
    logic        z_q, c7_q, h3_q, h11_q, c15_q;

    logic        op_ok, accept;
    logic [7:0]  lo_b, hi_b;
    logic [8:0]  lo_sum, hi_sum;
    logic        flags_valid;
    logic [3:0]  ext_flags;

`ifdef ALU16_SP_OFFSET_EN
    assign op_ok = 1'b1;
`else
    assign op_ok = (bus.i_Op != OP_ADDSPE);
`endif

    assign accept = bus.i_Start && op_ok && (state_q == S_IDLE || state_q == S_DONE);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_LOW;
            S_LOW:   state_d = S_HIGH;
            S_HIGH:  state_d = S_DONE;
            default: state_d = accept ? S_LOW : S_IDLE;
        endcase
    end

    always_comb begin
        lo_b = 8'h00;
        hi_b = 8'h00;
        case (op_q)
            OP_ADD16: begin lo_b = b_q[7:0]; hi_b = b_q[15:8]; end
            OP_INC16: begin lo_b = 8'h01;    hi_b = 8'h00;     end
            OP_DEC16: begin lo_b = 8'hFF;    hi_b = 8'hFF;     end
`ifdef ALU16_SP_OFFSET_EN
            OP_ADDSPE: begin lo_b = b_q[7:0]; hi_b = {8{b_q[7]}}; end
`endif
            default: ;
        endcase
    end

    // Nibble carries recovered as carry-into-bit = sum ^ a ^ b at bit 4 / bit 12.
    assign lo_sum = {1'b0, a_q[7:0]} + {1'b0, lo_b};
    assign hi_sum = {1'b0, a_q[15:8]} + {1'b0, hi_b} + {8'h00, c7_q};

    always_comb begin
        flags_valid = 1'b0;
        ext_flags   = 4'h0;
        if (state_q == S_DONE) begin
            if (op_q == OP_ADD16) begin
                flags_valid = 1'b1;
                ext_flags   = {z_q, 1'b0, h11_q, c15_q};
            end
`ifdef ALU16_SP_OFFSET_EN
            if (op_q == OP_ADDSPE) begin
                flags_valid = 1'b1;
                ext_flags   = {2'b00, h3_q, c7_q};
            end
`endif
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state_q  <= S_IDLE;
            op_q     <= OP_ADD16;
            a_q      <= 16'h0000;
            b_q      <= 16'h0000;
            z_q      <= 1'b0;
            result_q <= 16'h0000;
            c7_q     <= 1'b0;
            h3_q     <= 1'b0;
            h11_q    <= 1'b0;
            c15_q    <= 1'b0;
        end else if (bus.i_Enable) begin
            state_q <= state_d;
            if (accept) begin
                op_q <= bus.i_Op;
                a_q  <= bus.i_A;
                b_q  <= bus.i_B;
                z_q  <= bus.i_F[3];
            end
            if (state_q == S_LOW) begin
                result_q[7:0] <= lo_sum[7:0];
                c7_q          <= lo_sum[8];
                h3_q          <= lo_sum[4] ^ a_q[4] ^ lo_b[4];
            end
            if (state_q == S_HIGH) begin
                result_q[15:8] <= hi_sum[7:0];
                c15_q          <= hi_sum[8];
                h11_q          <= hi_sum[4] ^ a_q[12] ^ hi_b[4];
            end
        end
    end

    assign bus.o_Busy           = (state_q == S_LOW) || (state_q == S_HIGH);
    assign bus.o_Done           = (state_q == S_DONE);
    assign bus.o_Result         = result_q;
    assign bus.o_Flags_Valid    = flags_valid;
    assign bus.o_External_Flags = ext_flags;
endmodule

// File: tb/tb_alu16_unit.sv
// Directed self-checking bench for alu16_unit with an expected-result scoreboard queue.
module tb_alu16_unit;
    logic i_Clk = 1'b0;
    logic i_Rst = 1'b1;
    alu16_unit_if bus();

    alu16_unit dut (.i_Clk(i_Clk), .i_Rst(i_Rst), .bus(bus.slave));

    always #5 i_Clk = ~i_Clk;

    typedef struct {
        logic [15:0] res;
        logic [3:0]  fl;
        logic        v;
    } exp_t;
    exp_t sb[$];

    int tests = 0;
    int fails = 0;

    task automatic tick();
        @(posedge i_Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"},  {31'd0, bus.o_Busy}, 0);
        check({tag, "_done"},  {31'd0, bus.o_Done}, 0);
        check({tag, "_valid"}, {31'd0, bus.o_Flags_Valid}, 0);
        check({tag, "_ext"},   {28'd0, bus.o_External_Flags}, 0);
    endtask

    // Drives one start cycle and records the expectation; inputs are then scrambled to prove latching.
    task automatic start_op(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                            input logic [3:0] f, input logic [15:0] res, input logic [3:0] fl,
                            input logic v);
        exp_t e;
        e.res = res; e.fl = fl; e.v = v;
        sb.push_back(e);
        bus.i_Op = op; bus.i_A = a; bus.i_B = b; bus.i_F = f; bus.i_Start = 1'b1;
        tick();
        bus.i_Start = 1'b0;
        bus.i_Op = ~op; bus.i_A = ~a; bus.i_B = ~b; bus.i_F = ~f;
    endtask

    // Waits (bounded) for o_Done; returns the cycle number at which it was seen (1 = first after start).
    task automatic wait_done(input string tag, output int cyc);
        cyc = 1;
        while (!bus.o_Done && cyc < 20) begin
            check({tag, "_ext_busy"}, {28'd0, bus.o_External_Flags}, 0);
            tick();
            cyc++;
        end
        check({tag, "_done_seen"}, {31'd0, bus.o_Done}, 1);
    endtask

    task automatic check_result(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 1, 0);
        end else begin
            e = sb.pop_front();
            check({tag, "_result"}, {16'd0, bus.o_Result}, {16'd0, e.res});
            check({tag, "_flags"},  {28'd0, bus.o_External_Flags}, {28'd0, e.fl});
            check({tag, "_valid"},  {31'd0, bus.o_Flags_Valid}, {31'd0, e.v});
            check({tag, "_busy_done"}, {31'd0, bus.o_Busy}, 0);
        end
    endtask

    task automatic run_op(input string tag, input logic [1:0] op, input logic [15:0] a,
                          input logic [15:0] b, input logic [3:0] f, input logic [15:0] res,
                          input logic [3:0] fl, input logic v);
        int cyc;
        start_op(op, a, b, f, res, fl, v);
        check({tag, "_busy_low"}, {31'd0, bus.o_Busy}, 1);
        wait_done(tag, cyc);
        check({tag, "_latency"}, cyc, 3);
        check_result(tag);
        tick();
        check({tag, "_back_idle"}, {31'd0, bus.o_Done}, 0);
    endtask

    initial begin
        int cyc;
        logic [23:0] snap;
        bus.i_Enable = 1'b1; bus.i_Start = 1'b0; bus.i_Op = 2'b00;
        bus.i_A = 16'h0; bus.i_B = 16'h0; bus.i_F = 4'h0;

        tick(); tick();
        check_idle_outputs("reset");
        check("reset_result", {16'd0, bus.o_Result}, 0);
        i_Rst = 1'b0;
        tick();

        run_op("add_h11",  2'b00, 16'h0FFF, 16'h0001, 4'b1000, 16'h1000, 4'b1010, 1'b1);
        run_op("add_wrap", 2'b00, 16'hFFFF, 16'h0001, 4'b0000, 16'h0000, 4'b0011, 1'b1);
        run_op("add_c15",  2'b00, 16'h8000, 16'h8000, 4'b0000, 16'h0000, 4'b0001, 1'b1);
        run_op("inc_wrap", 2'b01, 16'hFFFF, 16'h1234, 4'b1111, 16'h0000, 4'b0000, 1'b0);
        run_op("dec_wrap", 2'b10, 16'h0000, 16'h5678, 4'b1111, 16'hFFFF, 4'b0000, 1'b0);

`ifdef ALU16_SP_OFFSET_EN
        run_op("spe_pos", 2'b11, 16'hFFF8, 16'h0008, 4'b1111, 16'h0000, 4'b0011, 1'b1);
        run_op("spe_neg", 2'b11, 16'h0005, 16'h00FE, 4'b1111, 16'h0003, 4'b0011, 1'b1);
`else
        bus.i_Op = 2'b11; bus.i_A = 16'h1111; bus.i_Start = 1'b1;
        tick();
        bus.i_Start = 1'b0;
        check_idle_outputs("spe_off_idle");
        tick();
        check_idle_outputs("spe_off_idle2");
        // From DONE, an op 11 request drops back to IDLE.
        start_op(2'b00, 16'h0001, 16'h0002, 4'b0000, 16'h0003, 4'b0000, 1'b1);
        wait_done("spe_off_pre", cyc);
        check_result("spe_off_pre");
        bus.i_Op = 2'b11; bus.i_Start = 1'b1;
        tick();
        bus.i_Start = 1'b0;
        check_idle_outputs("spe_off_from_done");
        tick();
`endif

        // Reset during HIGH aborts without a Done pulse.
        bus.i_Op = 2'b00; bus.i_A = 16'h1234; bus.i_B = 16'h1111; bus.i_Start = 1'b1;
        tick();
        bus.i_Start = 1'b0;
        tick();
        check("rst_in_high_busy", {31'd0, bus.o_Busy}, 1);
        i_Rst = 1'b1;
        tick();
        i_Rst = 1'b0;
        check_idle_outputs("rst_abort");
        check("rst_abort_result", {16'd0, bus.o_Result}, 0);
        tick();
        check("rst_abort_no_done", {31'd0, bus.o_Done}, 0);

        // Start during HIGH is ignored.
        start_op(2'b00, 16'h0102, 16'h0304, 4'b0000, 16'h0406, 4'b0000, 1'b1);
        tick();
        bus.i_Op = 2'b01; bus.i_A = 16'hAAAA; bus.i_Start = 1'b1;
        tick();
        bus.i_Start = 1'b0;
        check("ign_high_done", {31'd0, bus.o_Done}, 1);
        check_result("ign_high");
        tick();
        check_idle_outputs("ign_high_after");

        // Start during DONE goes straight to LOW.
        start_op(2'b01, 16'h00FF, 16'h0000, 4'b0000, 16'h0100, 4'b0000, 1'b0);
        wait_done("b2b_first", cyc);
        check_result("b2b_first");
        start_op(2'b00, 16'h7FFF, 16'h7FFF, 4'b1000, 16'hFFFE, 4'b1010, 1'b1);
        check("b2b_low_busy", {31'd0, bus.o_Busy}, 1);
        check("b2b_low_done", {31'd0, bus.o_Done}, 0);
        wait_done("b2b_second", cyc);
        check("b2b_latency", cyc, 3);
        check_result("b2b_second");
        tick();

        // Enable low for two cycles while in LOW stretches latency to 5.
        start_op(2'b10, 16'h1000, 16'h0000, 4'b0000, 16'h0FFF, 4'b0000, 1'b0);
        snap = {bus.o_Busy, bus.o_Done, bus.o_Result, bus.o_Flags_Valid, bus.o_External_Flags};
        bus.i_Enable = 1'b0;
        tick();
        check("en_hold1", {8'd0, bus.o_Busy, bus.o_Done, bus.o_Result, bus.o_Flags_Valid,
                           bus.o_External_Flags}, {8'd0, snap});
        tick();
        check("en_hold2", {8'd0, bus.o_Busy, bus.o_Done, bus.o_Result, bus.o_Flags_Valid,
                           bus.o_External_Flags}, {8'd0, snap});
        bus.i_Enable = 1'b1;
        cyc = 3;
        while (!bus.o_Done && cyc < 20) begin
            tick();
            cyc++;
        end
        check("en_latency", cyc, 5);
        check_result("en_stretch");
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
